// File: rtl/adsr_pkg.sv
// Shared types and helpers for the ADSR envelope stage.
// Optional build macro: ADSR_HARD_RETRIG_EN (restart ATTACK from zero).
package adsr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } adsr_state_e;

  function automatic int unsigned env_max(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/adsr_envelope_if.sv
// Sample stream, envelope controls and scaled output of the ADSR stage.
// master drives samples and controls; slave is the envelope block.
interface adsr_envelope_if #(
  parameter int WAVE_WIDTH = 16,
  parameter int ENV_WIDTH  = 16
);
  logic [WAVE_WIDTH-1:0] sample_in;
  logic                  sample_valid;
  logic                  gate;
  logic [ENV_WIDTH-1:0]  attack_step;
  logic [ENV_WIDTH-1:0]  decay_step;
  logic [ENV_WIDTH-1:0]  sustain_level;
  logic [ENV_WIDTH-1:0]  release_step;
  logic [WAVE_WIDTH-1:0] out;
  logic                  out_valid;
  logic [ENV_WIDTH-1:0]  env_level;
  logic                  busy;

  modport master (
    output sample_in, sample_valid, gate,
    output attack_step, decay_step,
    output sustain_level, release_step,
    input  out, out_valid, env_level, busy
  );

  modport slave (
    input  sample_in, sample_valid, gate,
    input  attack_step, decay_step,
    input  sustain_level, release_step,
    output out, out_valid, env_level, busy
  );
endinterface

// File: rtl/adsr_env_fsm.sv
// ADSR state register and envelope arithmetic, advanced once per tick.
// Macro ADSR_HARD_RETRIG_EN: retrigger in RELEASE restarts from zero.
module adsr_env_fsm
  import adsr_pkg::*;
#(
  parameter int ENV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick_i,
  input  logic                 gate_i,
  input  logic [ENV_WIDTH-1:0] attack_step_i,
  input  logic [ENV_WIDTH-1:0] decay_step_i,
  input  logic [ENV_WIDTH-1:0] sustain_level_i,
  input  logic [ENV_WIDTH-1:0] release_step_i,
  output logic [ENV_WIDTH-1:0] env_o,
  output adsr_state_e          state_o
);

  localparam int EW = ENV_WIDTH;
  localparam logic [EW-1:0] EMAX = EW'(env_max(EW));

  adsr_state_e   state_q;
  logic [EW-1:0] env_q;
  logic [EW:0]   att_sum;
  logic [EW:0]   dec_thr;

  // One extra bit so step overflow is visible.
  assign att_sum = {1'b0, env_q} + {1'b0, attack_step_i};
  assign dec_thr = {1'b0, sustain_level_i} + {1'b0, decay_step_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      env_q   <= '0;
    end else if (tick_i) begin
      unique case (state_q)
        IDLE: begin
          if (gate_i) state_q <= ATTACK;
        end
        ATTACK: begin
          if (!gate_i) begin
            state_q <= RELEASE;
          end else if (att_sum >= {1'b0, EMAX} ||
                       attack_step_i == '0) begin
            env_q   <= EMAX;
            state_q <= DECAY;
          end else begin
            env_q <= att_sum[EW-1:0];
          end
        end
        DECAY: begin
          if (!gate_i) begin
            state_q <= RELEASE;
          end else if ({1'b0, env_q} <= dec_thr ||
                       decay_step_i == '0) begin
            env_q   <= sustain_level_i;
            state_q <= SUSTAIN;
          end else begin
            env_q <= env_q - decay_step_i;
          end
        end
        SUSTAIN: begin
          if (!gate_i) state_q <= RELEASE;
          else env_q <= sustain_level_i;
        end
        RELEASE: begin
          if (gate_i) begin
            state_q <= ATTACK;
`ifdef ADSR_HARD_RETRIG_EN
            env_q   <= '0;
`endif
          end else if (env_q <= release_step_i ||
                       release_step_i == '0) begin
            env_q   <= '0;
            state_q <= IDLE;
          end else begin
            env_q <= env_q - release_step_i;
          end
        end
        default: begin
          state_q <= IDLE;
          env_q   <= '0;
        end
      endcase
    end
  end

  assign env_o   = env_q;
  assign state_o = state_q;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: centres each sample, scales it by the
// envelope level and re-biases it. Macro: ADSR_HARD_RETRIG_EN.
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int WAVE_WIDTH = 16,
  parameter int ENV_WIDTH  = 16
) (
  input logic             clk,
  input logic             rst,
  adsr_envelope_if.slave  bus
);

  localparam int WW = WAVE_WIDTH;
  localparam int EW = ENV_WIDTH;
  localparam logic [WW-1:0] MID = {1'b1, {(WW-1){1'b0}}};

  logic [EW-1:0] env;
  adsr_state_e   state;

  adsr_env_fsm #(.ENV_WIDTH(EW)) u_fsm (
    .clk             (clk),
    .rst             (rst),
    .tick_i          (bus.sample_valid),
    .gate_i          (bus.gate),
    .attack_step_i   (bus.attack_step),
    .decay_step_i    (bus.decay_step),
    .sustain_level_i (bus.sustain_level),
    .release_step_i  (bus.release_step),
    .env_o           (env),
    .state_o         (state)
  );

  logic signed [WW:0]      s_d;
  logic signed [WW+EW+1:0] p_d;
  logic [WW-1:0]           out_d;
  logic [WW-1:0]           out_q;
  logic                    ov_q;
  logic                    unused_p;

  // Bits [EW +: WW] of the product equal (p >>> EW) truncated.
  assign s_d   = $signed({1'b0, bus.sample_in}) - $signed({1'b0, MID});
  assign p_d   = s_d * $signed({1'b0, env});
  assign out_d = p_d[EW +: WW] + MID;
  assign unused_p = ^{p_d[WW+EW+1:WW+EW], p_d[EW-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= MID;
      ov_q  <= 1'b0;
    end else begin
      ov_q <= bus.sample_valid;
      if (bus.sample_valid) out_q <= out_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = ov_q;
  assign bus.env_level = env;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with a per-cycle reference model.
// Expected retrigger values follow ADSR_HARD_RETRIG_EN when defined.
module tb_adsr_envelope;
  import adsr_pkg::*;

  logic clk;
  logic rst;
  bit   armed;
  int   checks;
  int   errors;

  adsr_envelope_if #(.WAVE_WIDTH(16), .ENV_WIDTH(16)) bus ();

  adsr_envelope #(.WAVE_WIDTH(16), .ENV_WIDTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    adsr_state_e st;
    int          env;
  } mst_t;

  mst_t m;
  int   m_out;
  bit   m_ov;

  function automatic mst_t model_step(mst_t c, bit g,
                                      int a, int d, int s, int r);
    mst_t n = c;
    case (c.st)
      IDLE: if (g) n.st = ATTACK;
      ATTACK:
        if (!g) n.st = RELEASE;
        else if (a == 0 || c.env + a >= 65535) begin
          n.env = 65535;
          n.st  = DECAY;
        end else n.env = c.env + a;
      DECAY:
        if (!g) n.st = RELEASE;
        else if (d == 0 || c.env <= s + d) begin
          n.env = s;
          n.st  = SUSTAIN;
        end else n.env = c.env - d;
      SUSTAIN:
        if (!g) n.st = RELEASE;
        else n.env = s;
      RELEASE:
        if (g) begin
          n.st = ATTACK;
`ifdef ADSR_HARD_RETRIG_EN
          n.env = 0;
`endif
        end else if (r == 0 || c.env <= r) begin
          n.env = 0;
          n.st  = IDLE;
        end else n.env = c.env - r;
      default: n.st = IDLE;
    endcase
    return n;
  endfunction

  // floor(centred * gain / 65536) re-biased, kept to 16 bits
  function automatic int scale(int smp, int env);
    longint p = longint'(smp - 32768) * longint'(env);
    longint q = p >>> 16;
    return int'((q + 32768) & 64'hFFFF);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m     <= '{IDLE, 0};
      m_out <= 32768;
      m_ov  <= 1'b0;
    end else begin
      m_ov <= bus.sample_valid;
      if (bus.sample_valid) begin
        m_out <= scale(int'(bus.sample_in), m.env);
        m <= model_step(m, bus.gate,
                        int'(bus.attack_step), int'(bus.decay_step),
                        int'(bus.sustain_level), int'(bus.release_step));
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("m_ov", 32'(bus.out_valid), 32'(m_ov));
      chk("m_env", 32'(bus.env_level), m.env);
      chk("m_busy", 32'(bus.busy), 32'(m.st != IDLE));
      chk("m_state", 32'(u_dut.u_fsm.state_o), 32'(m.st));
      if (m_ov) chk("m_out", 32'(bus.out), m_out);
    end
  end

  task automatic step(input bit g, input bit v, input logic [15:0] smp);
    bus.gate         = g;
    bus.sample_valid = v;
    bus.sample_in    = smp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    armed  = 1'b0;
    rst    = 1'b1;
    bus.gate          = 1'b0;
    bus.sample_valid  = 1'b0;
    bus.sample_in     = 16'h8000;
    bus.attack_step   = 16'h4000;
    bus.decay_step    = 16'h1000;
    bus.sustain_level = 16'hC000;
    bus.release_step  = 16'h0800;
    @(posedge clk);
    #1;
    armed = 1'b1;
    step(0, 0, 16'h8000);
    chk("rst_env", 32'(bus.env_level), 0);
    chk("rst_out", 32'(bus.out), 32'h8000);
    chk("rst_ov", 32'(bus.out_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    step(0, 0, 16'h8000);

    step(1, 1, 16'h8000);
    chk("atk_enter_busy", 32'(bus.busy), 1);
    chk("atk_enter_env", 32'(bus.env_level), 0);
    step(1, 1, 16'h8000);
    chk("atk1", 32'(bus.env_level), 32'h4000);
    step(1, 1, 16'h8000);
    chk("atk2", 32'(bus.env_level), 32'h8000);
    step(1, 1, 16'h8000);
    chk("atk3", 32'(bus.env_level), 32'hC000);
    step(1, 1, 16'h8000);
    chk("atk_top", 32'(bus.env_level), 32'hFFFF);
    chk("atk_to_decay", 32'(u_dut.u_fsm.state_o), 32'(DECAY));

    step(1, 1, 16'hFFFF);
    chk("dec1", 32'(bus.env_level), 32'hEFFF);
    chk("scale_full_pos", 32'(bus.out), 32'hFFFE);
    step(1, 1, 16'h8000);
    chk("dec2", 32'(bus.env_level), 32'hDFFF);
    step(1, 1, 16'h8000);
    chk("dec3", 32'(bus.env_level), 32'hCFFF);
    step(1, 1, 16'h8000);
    chk("sus_enter", 32'(bus.env_level), 32'hC000);
    chk("sus_state", 32'(u_dut.u_fsm.state_o), 32'(SUSTAIN));
    bus.sustain_level = 16'hA000;
    step(1, 1, 16'h8000);
    chk("sus_live", 32'(bus.env_level), 32'hA000);
    step(1, 0, 16'h1234);
    chk("idle_tick_ov", 32'(bus.out_valid), 0);
    chk("idle_tick_env", 32'(bus.env_level), 32'hA000);

    step(0, 1, 16'h8000);
    chk("rel_hold", 32'(bus.env_level), 32'hA000);
    for (int i = 0; i < 14; i++) step(0, 1, 16'h8000);
    chk("rel_ramp", 32'(bus.env_level), 32'h3000);
    step(1, 1, 16'h8000);
`ifdef ADSR_HARD_RETRIG_EN
    chk("retrig_env", 32'(bus.env_level), 32'h0000);
`else
    chk("retrig_env", 32'(bus.env_level), 32'h3000);
`endif
    step(1, 1, 16'h8000);
`ifdef ADSR_HARD_RETRIG_EN
    chk("retrig_next", 32'(bus.env_level), 32'h4000);
`else
    chk("retrig_next", 32'(bus.env_level), 32'h7000);
`endif

    bus.sustain_level = 16'hFFFF;
    for (int i = 0; i < 3; i++) step(1, 1, 16'h8000);
    chk("atk2_top", 32'(bus.env_level), 32'hFFFF);
    step(1, 1, 16'h8000);
    chk("dec_max_sus", 32'(u_dut.u_fsm.state_o), 32'(SUSTAIN));
    step(1, 1, 16'hFFFF);
    chk("scale_pos", 32'(bus.out), 32'hFFFE);
    step(1, 1, 16'h0000);
    chk("scale_neg", 32'(bus.out), 32'h0000);
    step(1, 1, 16'h8000);
    chk("scale_mid", 32'(bus.out), 32'h8000);

    bus.release_step = 16'h0000;
    step(0, 1, 16'h8000);
    chk("rel0_hold", 32'(bus.env_level), 32'hFFFF);
    step(0, 1, 16'h8000);
    chk("rel0_env", 32'(bus.env_level), 0);
    chk("rel0_busy", 32'(bus.busy), 0);

    step(0, 1, 16'hFFFF);
    chk("env0_out", 32'(bus.out), 32'h8000);
    chk("env0_ov", 32'(bus.out_valid), 1);
    step(0, 0, 16'h0000);
    chk("env0_ov_drop", 32'(bus.out_valid), 0);
    step(0, 1, 16'h0000);
    chk("env0_out_lo", 32'(bus.out), 32'h8000);

    step(1, 1, 16'hFFFF);
    step(1, 1, 16'hFFFF);
    chk("pre_rst_env", 32'(bus.env_level), 32'h4000);
    rst = 1'b1;
    step(1, 1, 16'hFFFF);
    chk("mid_rst_env", 32'(bus.env_level), 0);
    chk("mid_rst_out", 32'(bus.out), 32'h8000);
    chk("mid_rst_ov", 32'(bus.out_valid), 0);
    chk("mid_rst_busy", 32'(bus.busy), 0);
    rst = 1'b0;
    step(1, 1, 16'h8000);
    chk("post_rst_atk", 32'(u_dut.u_fsm.state_o), 32'(ATTACK));
    step(1, 1, 16'h8000);
    chk("post_rst_env", 32'(bus.env_level), 32'h4000);
    step(0, 0, 16'h8000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
